// File: rtl/cond_flags_unit_if.sv
// ----------------------------------------------------------------------------
// cond_flags_unit_if
//
// Bundles the execute-stage signals exchanged with cond_flags_unit.
//   master : the execute-stage control / ALU side. It drives instruction
//            control, ALU flags and the counter clear, and receives the gated
//            write enables, flags and counters.
//   slave  : cond_flags_unit itself.
//
// Signals driven by the master:
//   InstrValid, Stall, Flush, Cond[3:0], FlagW[1:0], PCS, RegW, MemW, NoWrite,
//   ALUFlags[3:0] ({N,Z,C,V}), CountClr
// Signals driven by the slave:
//   CondEx, PCSrc, RegWrite, MemWrite, Flags[3:0], CarryOut,
//   InstrCount[COUNT_W-1:0], CondFailCount[COUNT_W-1:0]
// ----------------------------------------------------------------------------
interface cond_flags_unit_if #(
  parameter int unsigned COUNT_W = 16
);

  // Instruction control from the execute stage
  logic               InstrValid;
  logic               Stall;
  logic               Flush;
  logic [3:0]         Cond;
  logic [1:0]         FlagW;
  logic               PCS;
  logic               RegW;
  logic               MemW;
  logic               NoWrite;
  logic [3:0]         ALUFlags;
  logic               CountClr;

  // Results from the flags unit
  logic               CondEx;
  logic               PCSrc;
  logic               RegWrite;
  logic               MemWrite;
  logic [3:0]         Flags;
  logic               CarryOut;
  logic [COUNT_W-1:0] InstrCount;
  logic [COUNT_W-1:0] CondFailCount;

  modport master (
    output InstrValid, Stall, Flush, Cond, FlagW, PCS, RegW, MemW, NoWrite, ALUFlags,
           CountClr,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, CarryOut, InstrCount, CondFailCount
  );

  modport slave (
    input  InstrValid, Stall, Flush, Cond, FlagW, PCS, RegW, MemW, NoWrite, ALUFlags,
           CountClr,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, CarryOut, InstrCount, CondFailCount
  );

endinterface

// File: rtl/cond_flags_unit.sv
// ----------------------------------------------------------------------------
// cond_flags_unit
//
// Execute-stage companion to the ALU. Holds the architectural {N,Z,C,V} flag
// register, evaluates the ARM condition field against it, gates the PC,
// register-file and memory write enables for conditional execution, and keeps
// saturating counters of executed and condition-failed instructions.
//
// Ports:
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : cond_flags_unit_if.slave carrying instruction control, ALU flags,
//           gated write enables, registered flags, carry and counters
//
// Timing notes:
//   - CondEx is computed only from the registered flags. A flag update made by
//     the instruction in execute becomes visible to the next instruction.
//   - Write gating is purely combinational. Stall does not gate the enables;
//     the downstream pipeline register hold takes care of stalls.
// ----------------------------------------------------------------------------
module cond_flags_unit #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  cond_flags_unit_if.slave     bus
);

  // ARM condition field encodings; 4'b1111 falls to the default and passes.
  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110
  } cond_e;

  localparam logic [COUNT_W-1:0] CntMax = {COUNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]         flags_q,     flags_d;
  logic [COUNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [COUNT_W-1:0] fail_cnt_q,  fail_cnt_d;

  // --------------------------------------------------------------------------
  // Flag unpacking (registered flags only, no bypass from ALUFlags)
  // --------------------------------------------------------------------------
  logic flag_n, flag_z, flag_c, flag_v;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // --------------------------------------------------------------------------
  // Condition decode
  // --------------------------------------------------------------------------
  logic cond_ex;
  logic n_eq_v;

  assign n_eq_v = (flag_n == flag_v);

  always_comb begin
    cond_ex = 1'b1;
    case (cond_e'(bus.Cond))
      CondEq:  cond_ex = flag_z;
      CondNe:  cond_ex = ~flag_z;
      CondCs:  cond_ex = flag_c;
      CondCc:  cond_ex = ~flag_c;
      CondMi:  cond_ex = flag_n;
      CondPl:  cond_ex = ~flag_n;
      CondVs:  cond_ex = flag_v;
      CondVc:  cond_ex = ~flag_v;
      CondHi:  cond_ex = flag_c & ~flag_z;
      CondLs:  cond_ex = ~flag_c | flag_z;
      CondGe:  cond_ex = n_eq_v;
      CondLt:  cond_ex = ~n_eq_v;
      CondGt:  cond_ex = ~flag_z & n_eq_v;
      CondLe:  cond_ex = flag_z | ~n_eq_v;
      CondAl:  cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write gating
  // --------------------------------------------------------------------------
  logic wr_ok;

  // Flush squashes the instruction regardless of Stall.
  assign wr_ok = cond_ex & ~bus.Flush;

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & wr_ok;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & wr_ok;
  assign bus.MemWrite = bus.MemW & wr_ok;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic upd;
  logic flag_upd;

  // A real instruction retires from execute this cycle.
  assign upd      = bus.InstrValid & ~bus.Stall & ~bus.Flush;
  assign flag_upd = upd & cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (flag_upd) begin
      if (bus.FlagW[1]) begin
        flags_d[3:2] = bus.ALUFlags[3:2];
      end
      if (bus.FlagW[0]) begin
        flags_d[1:0] = bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    if (bus.CountClr) begin
      // Clear wins over any increment in the same cycle.
      instr_cnt_d = '0;
      fail_cnt_d  = '0;
    end else if (upd) begin
      if (instr_cnt_q != CntMax) begin
        instr_cnt_d = instr_cnt_q + 1'b1;
      end
      if (!cond_ex && (fail_cnt_q != CntMax)) begin
        fail_cnt_d = fail_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flags_q     <= 4'b0000;
      instr_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      flags_q     <= flags_d;
      instr_cnt_q <= instr_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  assign bus.Flags         = flags_q;
  assign bus.CarryOut      = flags_q[1];
  assign bus.InstrCount    = instr_cnt_q;
  assign bus.CondFailCount = fail_cnt_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// ----------------------------------------------------------------------------
// tb_cond_flags_unit
//
// Directed steps followed by a randomized run, all compared against a
// behavioural model of the flag register, condition table and counters.
// Uses COUNT_W=4 so counter saturation is reached quickly.
// ----------------------------------------------------------------------------
module tb_cond_flags_unit;

  localparam int unsigned CW     = 4;
  localparam int          CntMax = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  cond_flags_unit_if #(.COUNT_W(CW)) bus_if ();

  cond_flags_unit #(.COUNT_W(CW)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Model state
  bit m_n, m_z, m_c, m_v;
  int m_ic, m_fc;

  // Condition table: even codes test a base predicate, odd codes its inverse.
  function automatic bit cond_pass(logic [3:0] c, bit n, bit z, bit cf, bit v);
    bit base;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit valid, input bit stall, input bit flush,
                        input logic [3:0] cond, input logic [1:0] flagw,
                        input bit pcs, input bit regw, input bit memw, input bit nowrite,
                        input logic [3:0] alu, input bit clr);
    @(negedge clk);
    bus_if.InstrValid = valid;
    bus_if.Stall      = stall;
    bus_if.Flush      = flush;
    bus_if.Cond       = cond;
    bus_if.FlagW      = flagw;
    bus_if.PCS        = pcs;
    bus_if.RegW       = regw;
    bus_if.MemW       = memw;
    bus_if.NoWrite    = nowrite;
    bus_if.ALUFlags   = alu;
    bus_if.CountClr   = clr;
    #1;
  endtask

  task automatic check_model();
    bit pass;
    bit live;
    pass = cond_pass(bus_if.Cond, m_n, m_z, m_c, m_v);
    live = pass && !bus_if.Flush;
    check("cond_ex",   32'(bus_if.CondEx),   32'(pass));
    check("pc_src",    32'(bus_if.PCSrc),    32'(bus_if.PCS && live));
    check("reg_write", 32'(bus_if.RegWrite), 32'(bus_if.RegW && !bus_if.NoWrite && live));
    check("mem_write", 32'(bus_if.MemWrite), 32'(bus_if.MemW && live));
    check("flags",     32'(bus_if.Flags),    32'({m_n, m_z, m_c, m_v}));
    check("carry_out", 32'(bus_if.CarryOut), 32'(m_c));
    check("instr_cnt", 32'(bus_if.InstrCount),    32'(m_ic));
    check("fail_cnt",  32'(bus_if.CondFailCount), 32'(m_fc));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    bit pass;
    bit upd;
    pass = cond_pass(bus_if.Cond, m_n, m_z, m_c, m_v);
    upd  = bus_if.InstrValid && !bus_if.Stall && !bus_if.Flush;
    if (bus_if.CountClr) begin
      m_ic = 0;
      m_fc = 0;
    end else if (upd) begin
      m_ic = (m_ic < CntMax) ? m_ic + 1 : CntMax;
      if (!pass) m_fc = (m_fc < CntMax) ? m_fc + 1 : CntMax;
    end
    if (upd && pass) begin
      if (bus_if.FlagW[1]) begin
        m_n = bus_if.ALUFlags[3];
        m_z = bus_if.ALUFlags[2];
      end
      if (bus_if.FlagW[0]) begin
        m_c = bus_if.ALUFlags[1];
        m_v = bus_if.ALUFlags[0];
      end
    end
  endtask

  // Check current outputs, then clock once; returns at posedge+1.
  task automatic step();
    check_model();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_ic = 0;
    m_fc = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b0;
    bus_if.InstrValid = 1'b0;
    bus_if.Stall      = 1'b0;
    bus_if.Flush      = 1'b0;
    bus_if.Cond       = 4'b0000;
    bus_if.FlagW      = 2'b00;
    bus_if.PCS        = 1'b0;
    bus_if.RegW       = 1'b0;
    bus_if.MemW       = 1'b0;
    bus_if.NoWrite    = 1'b0;
    bus_if.ALUFlags   = 4'b0000;
    bus_if.CountClr   = 1'b0;

    // Reset state
    #12;
    check("rst_flags", 32'(bus_if.Flags), 32'h0);
    check("rst_carry", 32'(bus_if.CarryOut), 32'h0);
    check("rst_icnt",  32'(bus_if.InstrCount), 32'h0);
    check("rst_fcnt",  32'(bus_if.CondFailCount), 32'h0);
    rst_n = 1'b1;

    // EQ fails on reset flags
    set_in(1, 0, 0, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 0);
    check("eq_after_rst", 32'(bus_if.CondEx), 32'h0);
    check("eq_regwrite",  32'(bus_if.RegWrite), 32'h0);
    step();
    check("eq_failcnt",   32'(bus_if.CondFailCount), 32'h1);

    // AL writes N,Z,C,V = 0110
    set_in(1, 0, 0, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b0110, 0);
    check("al_regwrite", 32'(bus_if.RegWrite), 32'h1);
    step();
    check("flags_0110", 32'(bus_if.Flags), 32'h6);
    check("carry_1",    32'(bus_if.CarryOut), 32'h1);

    set_in(1, 0, 0, 4'b1000, 2'b00, 0, 0, 0, 0, 4'b0000, 0);
    check("hi_zset", 32'(bus_if.CondEx), 32'h0);
    step();
    set_in(1, 0, 0, 4'b0010, 2'b00, 0, 0, 0, 0, 4'b0000, 0);
    check("cs_cset", 32'(bus_if.CondEx), 32'h1);
    step();

    // Partial flag writes
    set_in(1, 0, 0, 4'b1110, 2'b10, 0, 0, 0, 0, 4'b1001, 0);
    step();
    check("flags_1010", 32'(bus_if.Flags), 32'hA);
    set_in(1, 0, 0, 4'b1010, 2'b00, 0, 0, 0, 0, 4'b0000, 0);
    check("ge_n1v0", 32'(bus_if.CondEx), 32'h0);
    step();
    set_in(1, 0, 0, 4'b1110, 2'b01, 0, 0, 0, 0, 4'b0001, 0);
    step();
    check("flags_1001", 32'(bus_if.Flags), 32'h9);
    set_in(1, 0, 0, 4'b1010, 2'b00, 0, 0, 0, 0, 4'b0000, 0);
    check("ge_n1v1", 32'(bus_if.CondEx), 32'h1);
    step();

    // Stall: enables follow CondEx, no state change
    set_in(1, 1, 0, 4'b1110, 2'b11, 1, 1, 1, 0, 4'b1111, 0);
    check("stall_regwrite", 32'(bus_if.RegWrite), 32'h1);
    step();
    check("stall_flags", 32'(bus_if.Flags), 32'h9);
    // Flush (with stall too): enables forced low
    set_in(1, 1, 1, 4'b1110, 2'b11, 1, 1, 1, 0, 4'b1111, 0);
    check("flush_pcsrc", 32'(bus_if.PCSrc), 32'h0);
    check("flush_memw",  32'(bus_if.MemWrite), 32'h0);
    step();
    set_in(1, 0, 1, 4'b1110, 2'b11, 1, 1, 1, 0, 4'b1111, 0);
    step();
    check("flush_flags", 32'(bus_if.Flags), 32'h9);

    // Saturation
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 0, 4'b1110, 2'b00, 0, 1, 0, 0, 4'b0000, 0);
      step();
    end
    check("icnt_sat", 32'(bus_if.InstrCount), 32'(CntMax));
    set_in(1, 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 1);
    step();
    check("clr_icnt", 32'(bus_if.InstrCount), 32'h0);
    check("clr_fcnt", 32'(bus_if.CondFailCount), 32'h0);

    // Async reset mid-operation with all flags set
    set_in(1, 0, 0, 4'b1110, 2'b11, 0, 0, 0, 0, 4'b1111, 0);
    step();
    check("flags_1111", 32'(bus_if.Flags), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("arst_flags", 32'(bus_if.Flags), 32'h0);
    check("arst_carry", 32'(bus_if.CarryOut), 32'h0);
    check("arst_icnt",  32'(bus_if.InstrCount), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    set_in(1, 0, 0, 4'b0001, 2'b00, 0, 0, 0, 0, 4'b0000, 0);
    check("ne_after_rst", 32'(bus_if.CondEx), 32'h1);
    step();

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(3) != 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
             4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(3) == 0), 4'($urandom), ($urandom_range(15) == 0));
      step();
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Execute-stage neighbour of the ALU. Holds the architectural N,Z,C,V flag register.
- Consumes ALUFlags and feeds the registered carry back to the ALU carry input.
- Evaluates the 4-bit ARM condition field and gates PC, register and memory writes for conditional execution.
- Keeps saturating counters of executed and condition-failed instructions for performance debug.

Parameters:
COUNT_W, 16, width of each saturating instruction counter

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
InstrValid  in  1  a real instruction is in execute this cycle
Stall  in  1  execute stage held; no state update
Flush  in  1  instruction in execute is squashed; no state update, all write enables forced 0
Cond  in  4  instruction condition field
FlagW  in  2  bit1: update N,Z; bit0: update C,V
PCS  in  1  instruction writes PC
RegW  in  1  instruction writes register file
MemW  in  1  instruction writes memory
NoWrite  in  1  compare-type instruction; suppress RegWrite
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
CountClr  in  1  synchronous clear of both counters
CondEx  out  1  condition passed, evaluated against registered flags
PCSrc  out  1  gated PC write
RegWrite  out  1  gated register write
MemWrite  out  1  gated memory write
Flags  out  4  registered {N,Z,C,V}
CarryOut  out  1  registered C, to the ALU carry input
InstrCount  out  COUNT_W  executed-instruction counter
CondFailCount  out  COUNT_W  condition-failed counter

Behaviour:
- RESET low (async): Flags=4'b0000, InstrCount=0, CondFailCount=0. CarryOut=0 follows.
- Condition decode (combinational, on registered Flags only; no bypass from ALUFlags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1
- Write gating (combinational, zero latency):
  - PCSrc = PCS & CondEx & ~Flush
  - RegWrite = RegW & ~NoWrite & CondEx & ~Flush
  - MemWrite = MemW & CondEx & ~Flush
- Stall does not gate these outputs; the downstream register hold handles stalls.
- upd = InstrValid & ~Stall & ~Flush.
- Flag update on rising CLK when upd & CondEx:
  - FlagW[1]: N,Z <= ALUFlags[3:2]
  - FlagW[0]: C,V <= ALUFlags[1:0]
  - Unselected flags hold.
- Updated flags are visible to CondEx of the next cycle's instruction. One-cycle latency, no forwarding.
- Counters (priority order):
  - CountClr: both <= 0. Overrides any increment in the same cycle.
  - Else if upd: InstrCount += 1. CondFailCount += 1 if ~CondEx.
  - Each counter saturates at 2^COUNT_W-1. No wrap.
- Stall and Flush both high: Flush dominates gating (outputs 0). No state change.
- InstrValid low: flags and counters hold. Write gating is still computed; upstream drives enables 0 for bubbles.
- RESET asserted mid-operation: immediate async clear. The first instruction after release sees Flags=0, so EQ fails, NE passes, AL passes.

Test Plan:
- Reset then Cond=0000, RegW=1, InstrValid=1 -> CondEx=0, RegWrite=0, CondFailCount=1 after edge. Cond=1110 -> RegWrite=1.
- ALUFlags=4'b0110, FlagW=2'b11, Cond=1110, one edge -> Flags=0110, CarryOut=1. Next cycle Cond=1000 (HI) -> CondEx=0 (Z=1). Cond=0010 (CS) -> CondEx=1.
- Flags=0110, ALUFlags=4'b1001, FlagW=2'b10 -> Flags=1010 (C,V held). Then FlagW=2'b01 with ALUFlags=0001 -> Flags=1001. Check GE=0 with N=1,V=0, then GE=1 with N=1,V=1.
- Stall=1 with FlagW=11, ALUFlags=1111 -> Flags and counters unchanged, RegWrite still follows CondEx. Flush=1 -> PCSrc=RegWrite=MemWrite=0, no update.
- COUNT_W=4: 20 valid AL instructions -> InstrCount=15 and stays. CountClr together with upd -> both counters 0.
- RESET low asynchronously between edges with Flags=1111 -> Flags=0 immediately, CarryOut=0. Counters are 0 before the next CLK edge.
